// File: rtl/pp_seq_multiplier.sv
// Sequential partial-product multiplier: ROWS_PER_CYCLE rows of A & b[j] are accumulated per clock.
// Latency N = WIDTH_B/ROWS_PER_CYCLE clocks from accept to out_valid; no new operand is accepted until the result is taken.
module pp_seq_multiplier #(
    parameter int WIDTH_A        = 8,
    parameter int WIDTH_B        = 8,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         in_a,
    input  logic [WIDTH_B-1:0]         in_b,
    input  logic                       in_signed,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] out_p,
    output logic                       busy
);

    localparam int W     = WIDTH_A + WIDTH_B;
    localparam int N     = WIDTH_B / ROWS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    generate
        if (WIDTH_A < 2 || WIDTH_B < 2) begin : g_bad_width
            $error("pp_seq_multiplier: WIDTH_A and WIDTH_B must be at least 2");
        end
        if (ROWS_PER_CYCLE < 1 || (WIDTH_B % ROWS_PER_CYCLE) != 0) begin : g_bad_rows
            $error("pp_seq_multiplier: ROWS_PER_CYCLE must divide WIDTH_B");
        end
    endgenerate

    logic [1:0]         state;
    logic [W-1:0]       a_sh;
    logic [WIDTH_B-1:0] b_sh;
    logic               sgn;
    logic [W-1:0]       acc;
    logic [CNT_W-1:0]   cnt;
    logic [W-1:0]       next_acc;
    logic               last_step;

    assign last_step = (cnt == CNT_W'(N - 1));

    // a_sh already carries the shift of earlier steps, so row k of this step is a_sh << k.
    // The very last row (B MSB) carries negative weight in signed mode.
    always_comb begin
        next_acc = acc;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            if (b_sh[k]) begin
                if (sgn && last_step && (k == ROWS_PER_CYCLE - 1)) begin
                    next_acc = next_acc - (a_sh << k);
                end else begin
                    next_acc = next_acc + (a_sh << k);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            sgn   <= 1'b0;
            acc   <= '0;
            cnt   <= '0;
            out_p <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= {{WIDTH_B{in_signed & in_a[WIDTH_A-1]}}, in_a};
                        b_sh  <= in_b;
                        sgn   <= in_signed;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= next_acc;
                    a_sh <= a_sh << ROWS_PER_CYCLE;
                    b_sh <= b_sh >> ROWS_PER_CYCLE;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_step) begin
                        out_p <= next_acc;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_pp_seq_multiplier.sv
// Scoreboard bench for pp_seq_multiplier: one instance with 1 row/clock, one with 4 rows/clock.
module tb_pp_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v0, r0, s0, ov0, or0, bz0;
    logic [7:0]  a0, b0;
    logic [15:0] p0;
    logic        v1, r1, s1, ov1, or1, bz1;
    logic [7:0]  a1, b1;
    logic [15:0] p1;

    pp_seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .ROWS_PER_CYCLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0),
        .in_signed(s0), .out_valid(ov0), .out_ready(or0), .out_p(p0), .busy(bz0)
    );

    pp_seq_multiplier #(.WIDTH_A(8), .WIDTH_B(8), .ROWS_PER_CYCLE(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
        .in_signed(s1), .out_valid(ov1), .out_ready(or1), .out_p(p1), .busy(bz1)
    );

    typedef struct {
        logic [15:0] p;
        int          rise;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    logic pv[2];
    int   bcnt[2];

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard monitor: product, latency and busy duration are compared on each rising out_valid.
    task automatic mon(input int d, input logic v, input logic b, input logic [15:0] p);
        exp_t e;
        int   n;
        n = (d == 0) ? 8 : 2;
        if (!rst_n) begin
            pv[d]   = 1'b0;
            bcnt[d] = 0;
            if (d == 0) q0.delete();
            else q1.delete();
            return;
        end
        if (b) bcnt[d]++;
        if (v && !pv[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                chk("unexpected_valid", 32'(v), 32'd0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else e = q1.pop_front();
                chk("product", 32'(p), 32'(e.p));
                chk("latency", 32'(cyc), 32'(e.rise));
                chk("busy_cycles", 32'(bcnt[d]), 32'(n));
            end
            bcnt[d] = 0;
        end
        pv[d] = v;
    endtask

    always @(negedge clk) begin
        mon(0, ov0, bz0, p0);
        mon(1, ov1, bz1, p1);
    end

    task automatic push(input int d, input logic [15:0] e, input int ac);
        exp_t x;
        x.p    = e;
        x.rise = ac + ((d == 0) ? 8 : 2);
        if (d == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [15:0] e, output int ac);
        int t;
        @(negedge clk);
        if (d == 0) begin v0 = 1'b1; a0 = a; b0 = b; s0 = s; end
        else begin v1 = 1'b1; a1 = a; b1 = b; s1 = s; end
        t = 0;
        while (!((d == 0) ? r0 : r1) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'((d == 0) ? r0 : r1), 32'd1);
        ac = cyc + 1;
        push(d, e, ac);
        @(negedge clk);
        if (d == 0) v0 = 1'b0;
        else v1 = 1'b0;
    endtask

    task automatic drain(input int d);
        int t;
        t = 0;
        while (((d == 0) ? (q0.size() != 0 || ov0) : (q1.size() != 0 || ov1)) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", 32'(t < 100), 32'd1);
    endtask

    task automatic txn(input int d, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] e);
        int ac;
        issue(d, a, b, s, e, ac);
        drain(d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  sa[4] = '{8'h0A, 8'hFF, 8'h80, 8'h33};
    logic [7:0]  sb[4] = '{8'h0B, 8'h02, 8'h80, 8'h03};
    logic [15:0] sp[4] = '{16'h006E, 16'h01FE, 16'h4000, 16'h0099};

    initial begin
        int ac;
        int prev;
        int t;
        rst_n = 1'b0;
        v0 = 0; a0 = 0; b0 = 0; s0 = 0; or0 = 1;
        v1 = 0; a1 = 0; b1 = 0; s1 = 0; or1 = 1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(r0), 32'd1);
        chk("rst_out_valid", 32'(ov0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_out_p", 32'(p0), 32'd0);
        chk("rst_in_ready_r4", 32'(r1), 32'd1);
        chk("rst_out_valid_r4", 32'(ov1), 32'd0);
        rst_n = 1'b1;

        // Unsigned and signed directed vectors, 1 row per clock
        txn(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        txn(0, 8'hFF, 8'h01, 1'b0, 16'h00FF);
        txn(0, 8'h80, 8'h80, 1'b1, 16'h4000);
        txn(0, 8'hFF, 8'h01, 1'b1, 16'hFFFF);
        txn(0, 8'h7F, 8'h80, 1'b1, 16'hC080);
        txn(0, 8'h00, 8'h80, 1'b1, 16'h0000);

        // Backpressure: result held while out_ready is low, new offers refused
        or0 = 1'b0;
        issue(0, 8'h12, 8'h34, 1'b0, 16'h03A8, ac);
        t = 0;
        while (!ov0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid_seen", 32'(ov0), 32'd1);
        v0 = 1'b1; a0 = 8'h77; b0 = 8'h66; s0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_p_stable", 32'(p0), 32'h03A8);
            chk("bp_in_ready_low", 32'(r0), 32'd0);
            chk("bp_out_valid_held", 32'(ov0), 32'd1);
        end
        v0 = 1'b0;
        or0 = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(ov0), 32'd0);
        chk("bp_release_idle", 32'(r0), 32'd1);
        chk("bp_release_busy", 32'(bz0), 32'd0);

        // Throughput: in_valid held high across a stream of four operand pairs
        @(negedge clk);
        v0 = 1'b1;
        s0 = 1'b0;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            a0 = sa[i];
            b0 = sb[i];
            t = 0;
            while (!r0 && t < 40) begin
                @(negedge clk);
                t++;
            end
            chk("stream_accept", 32'(r0), 32'd1);
            ac = cyc + 1;
            push(0, sp[i], ac);
            if (i > 0) chk("stream_spacing", 32'(ac - prev), 32'd10);
            prev = ac;
            @(negedge clk);
        end
        v0 = 1'b0;
        drain(0);

        // Reset mid-operation: in-flight product must vanish
        issue(0, 8'hAA, 8'h55, 1'b0, 16'h3872, ac);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 32'(r0), 32'd1);
        chk("abort_out_valid", 32'(ov0), 32'd0);
        chk("abort_busy", 32'(bz0), 32'd0);
        chk("abort_out_p", 32'(p0), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_valid", 32'(ov0), 32'd0);
        txn(0, 8'h03, 8'h05, 1'b0, 16'h000F);

        // Four rows per clock
        txn(1, 8'hA5, 8'h3C, 1'b0, 16'h26AC);
        txn(1, 8'hA5, 8'h3C, 1'b1, 16'hEAAC);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
